// File: rtl/alu_arbiter_seq_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_arbiter_seq_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;
    localparam int SH_W   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [OP_W-1:0] OP_000 = 3'b000;
    localparam logic [OP_W-1:0] OP_001 = 3'b001;
    localparam logic [OP_W-1:0] OP_010 = 3'b010;
    localparam logic [OP_W-1:0] OP_011 = 3'b011;
    localparam logic [OP_W-1:0] OP_100 = 3'b100;
    localparam logic [OP_W-1:0] OP_101 = 3'b101;
    localparam logic [OP_W-1:0] OP_110 = 3'b110;
    localparam logic [OP_W-1:0] OP_111 = 3'b111;

    // One ALU operation as presented by a requester and held on the alu_* bus.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [SH_W-1:0]   shift;
    } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter producing a one-hot grant.
// Latency: combinational.
// Backpressure: none; grant follows valid every cycle.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            // Contention goes to whichever requester was not served last.
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/alu_arbiter_seq.sv
// Shares one registered ALU between two requesters with round-robin grant.
// Latency: request handshake to result capture is ALU_LAT+1 cycles, response next.
// Backpressure: one op in flight; new requests wait until the response is taken.
module alu_arbiter_seq
    import alu_arbiter_seq_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SH_W-1:0]   req0_shift,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SH_W-1:0]   req1_shift,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic              resp0_zero,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic              resp1_zero,
    output logic [DATA_W-1:0] alu_sr1,
    output logic [DATA_W-1:0] alu_sr2,
    output logic [OP_W-1:0]   alu_os,
    output logic [SH_W-1:0]   alu_shift,
    input  logic [DATA_W-1:0] alu_rd,
    input  logic              alu_zeroflag,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    // ALU_LAT is limited to 1..7, so the countdown fits in three bits.
    localparam int LAT_W = 3;

    state_t            state;
    state_t            next_state;
    logic              last_grant;
    logic              gid;
    logic [LAT_W-1:0]  lat_cnt;
    logic [1:0]        grant;
    alu_req_t          alu_q;
    alu_req_t          req0_dat;
    alu_req_t          req1_dat;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;
    logic              hs_req;
    logic              hs_resp;
    logic              exec_done;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0_dat = '{op: req0_op, a: req0_a, b: req0_b, shift: req0_shift};
    assign req1_dat = '{op: req1_op, a: req1_a, b: req1_b, shift: req1_shift};

    assign req0_ready  = (state == IDLE) && grant[0];
    assign req1_ready  = (state == IDLE) && grant[1];
    assign hs_req      = req0_ready || req1_ready;
    // The countdown runs ALU_LAT..0, one cycle longer than ALU_LAT, so the
    // registered ALU output has settled before it is sampled.
    assign exec_done   = (state == EXEC) && (lat_cnt == '0);
    assign resp0_valid = (state == RESP) && !gid;
    assign resp1_valid = (state == RESP) && gid;
    assign hs_resp     = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);
    assign busy        = (state != IDLE);

    assign resp0_result = res_q;
    assign resp1_result = res_q;
    assign resp0_zero   = zero_q;
    assign resp1_zero   = zero_q;

    assign alu_sr1   = alu_q.a;
    assign alu_sr2   = alu_q.b;
    assign alu_os    = alu_q.op;
    assign alu_shift = alu_q.shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (hs_req)    next_state = EXEC;
            EXEC:    if (exec_done) next_state = RESP;
            RESP:    if (hs_resp)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_q      <= '0;
            gid        <= 1'b0;
            last_grant <= 1'b1;
            lat_cnt    <= '0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            op_count   <= '0;
        end else begin
            if (hs_req) begin
                gid     <= grant[1];
                alu_q   <= grant[1] ? req1_dat : req0_dat;
                lat_cnt <= LAT_W'(ALU_LAT);
            end else if ((state == EXEC) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (exec_done) begin
                res_q  <= alu_rd;
                zero_q <= alu_zeroflag;
            end
            if (hs_resp) begin
                op_count   <= op_count + CNT_W'(1);
                last_grant <= gid;
            end
        end
    end

endmodule
